// File: rtl/ddr_axil_pkg.sv
// ddr_axil_pkg: definitions shared by the axil_ddr_master initiator and the
// ddr_control AXI4-Lite slave port.
//   state_t      - initiator FSM state encoding (also exposed for debug)
//   RESP_*       - AXI4-Lite BRESP/RRESP encodings
package ddr_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

endpackage

// File: rtl/axil_ddr_master_if.sv
// axil_ddr_master_if: bundles the command port, the response port, the sticky
// stall flag and the five AXI4-Lite channels of the DDR initiator.
//   master modport - the initiator's view (drives cmd_ready, rsp_*, AXI VALIDs)
//   slave modport  - the harness/slave view (drives cmd_*, rsp_ready, AXI READYs)
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clock edge where both valid and ready are high. Once valid is raised
// it stays high, with its payload stable, until that transfer; ready may
// change freely and the source never waits on ready before raising valid.
interface axil_ddr_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // command port
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_wstrb;
  // response port
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_we;
  logic                  timeout;
  // AXI4-Lite channels
  logic [ADDR_W-1:0]     AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_W-1:0]     ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_W-1:0]     RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_we, timeout,
    input  rsp_ready,
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_we, timeout,
    output rsp_ready,
    input  AWADDR, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/axil_ddr_master_watchdog.sv
// axil_watchdog: saturating stall counter with a sticky flag.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - restart the count (bus-state entry or any handshake)
//   en         - count this cycle (a bus state is waiting on the slave)
//   flag_clr   - drop the sticky flag (next command accepted)
//   flag       - set in the same edge the count reaches TIMEOUT-1
module axil_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic flag_clr,
  output logic flag
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] SAT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      flag  <= 1'b0;
    end else begin
      if (clr)
        cnt_q <= '0;
      else if (en && cnt_q != SAT)
        cnt_q <= cnt_q + CW'(1);

      // The flag rises on the edge that moves the count onto SAT, so it is
      // visible after exactly TIMEOUT-1 stalled cycles.
      if (flag_clr)
        flag <= 1'b0;
      else if (en && !clr && cnt_q == SAT - CW'(1))
        flag <= 1'b1;
    end
  end

endmodule

// File: rtl/axil_ddr_master.sv
// axil_ddr_master: single-outstanding AXI4-Lite initiator toward ddr_control.
//   ACLK, ARESETN - clock, asynchronous active-low reset
//   bus           - command/response ports and AXI4-Lite channels (master view)
//   dbg_state     - current FSM state
// A write command issues AW and W together and waits for B; a read issues AR
// and waits for R. The captured response is held on rsp_* until rsp_ready.
module axil_ddr_master
  import ddr_axil_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  axil_ddr_master_if.master     bus,
  output state_t                dbg_state
);
  // Word-aligns the captured address: bits [1:0] always go out as zero.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  state_t state_q, state_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;
  logic                we_q;

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic bus_state;

  // Every VALID/READY output is a pure decode of registered state, so the
  // asynchronous reset drops them immediately.
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.AWVALID   = (state_q == ST_WADDR) && !aw_done_q;
  assign bus.WVALID    = (state_q == ST_WADDR) && !w_done_q;
  assign bus.BREADY    = (state_q == ST_WRESP);
  assign bus.ARVALID   = (state_q == ST_RADDR);
  assign bus.RREADY    = (state_q == ST_RDATA);
  assign bus.rsp_valid = (state_q == ST_RSP);

  assign bus.AWADDR    = addr_q;
  assign bus.ARADDR    = addr_q;
  assign bus.WDATA     = wdata_q;
  assign bus.WSTRB     = wstrb_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_resp  = resp_q;
  assign bus.rsp_we    = we_q;
  assign dbg_state     = state_q;

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign aw_hs  = bus.AWVALID && bus.AWREADY;
  assign w_hs   = bus.WVALID  && bus.WREADY;
  assign b_hs   = bus.BVALID  && bus.BREADY;
  assign ar_hs  = bus.ARVALID && bus.ARREADY;
  assign r_hs   = bus.RVALID  && bus.RREADY;

  assign bus_state = (state_q == ST_WADDR) || (state_q == ST_WRESP) ||
                     (state_q == ST_RADDR) || (state_q == ST_RDATA);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = bus.cmd_we ? ST_WADDR : ST_RADDR;
        end
      end
      ST_WADDR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // Covers AW first, W first, or both on the same edge.
        if (aw_done_d && w_done_d) state_d = ST_WRESP;
      end
      ST_WRESP: if (b_hs) state_d = ST_RSP;
      ST_RADDR: if (ar_hs) state_d = ST_RDATA;
      ST_RDATA: if (r_hs) state_d = ST_RSP;
      ST_RSP:   if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.cmd_addr & ADDR_MASK;
        wdata_q <= bus.cmd_wdata;
        wstrb_q <= bus.cmd_wstrb;
      end
      if (b_hs) begin
        rdata_q <= '0;
        resp_q  <= bus.BRESP;
        we_q    <= 1'b1;
      end
      // Read data is forwarded even when RRESP reports an error.
      if (r_hs) begin
        rdata_q <= bus.RDATA;
        resp_q  <= bus.RRESP;
        we_q    <= 1'b0;
      end
    end
  end

  axil_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .clr      (accept || aw_hs || w_hs || b_hs || ar_hs || r_hs),
    .en       (bus_state),
    .flag_clr (accept),
    .flag     (bus.timeout)
  );

endmodule

// File: doc/axil_ddr_master.md
# axil_ddr_master

AXI4-Lite initiator that turns single-word read/write commands from a simple valid/ready command port into AXI4-Lite transactions toward the `ddr_control` AXI4-Lite slave port. Sits between the CPU/test-harness side and the DDR2 controller, one outstanding transaction at a time. Returns read data and the bus response on a held response port. A watchdog flags transactions stalled by the slave.

## Interface
- `ADDR_W`, 32: address width on both the command port and the AXI port.
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits.
- `TIMEOUT`, 256: stall cycles without a handshake before `timeout` sets; ≥2.
- `ACLK` in 1: the single clock for the block.
- `ARESETN` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: byte address. Bits [1:0] are driven as 0 on the bus.
- `cmd_wdata` in DATA_W: write data.
- `cmd_wstrb` in DATA_W/8: write strobes.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_rdata` out DATA_W: read data; 0 for writes.
- `rsp_resp` out 2: captured BRESP or RRESP.
- `rsp_we` out 1: echoes `cmd_we` of the completed command.
- `timeout` out 1: sticky stall flag.
- `AWADDR` out ADDR_W, `AWVALID` out 1, `AWREADY` in 1.
- `WDATA` out DATA_W, `WSTRB` out DATA_W/8, `WVALID` out 1, `WREADY` in 1.
- `BRESP` in 2, `BVALID` in 1, `BREADY` out 1.
- `ARADDR` out ADDR_W, `ARVALID` out 1, `ARREADY` in 1.
- `RDATA` in DATA_W, `RRESP` in 2, `RVALID` in 1, `RREADY` out 1.

## Operation
- **States:** IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
- **Reset values:** state IDLE. All outputs are 0, except `cmd_ready`, which is 1.
- **IDLE**
  - `cmd_ready`=1 in IDLE only.
  - On accept, register address, data and strobes.
  - Go to WADDR if `cmd_we`=1, otherwise go to RADDR.
- **WADDR**
  - `AWVALID` and `WVALID` assert together.
  - Each valid drops independently on its own handshake. Flags `aw_done` and `w_done` record completion.
  - When both are done (either order, or the same cycle), go to WRESP.
- **WRESP**
  - `BREADY`=1.
  - On `BVALID`, capture `BRESP`, set `rsp_we`=1, and go to RSP.
- **RADDR**
  - `ARVALID`=1 until `ARREADY`, then go to RDATA.
- **RDATA**
  - `RREADY`=1.
  - On `RVALID`, capture `RDATA` and `RRESP`, and go to RSP.
- **RSP**
  - `rsp_valid`=1, and `rsp_*` is held stable until `rsp_ready`, then go to IDLE.
  - `rsp_ready` already high on entry gives a one-cycle response.
- **AXI rules**
  - A VALID, once raised, never drops before its READY. Payload is stable while VALID is high.
  - The block never waits on READY before raising VALID.
- **Responses**
  - SLVERR and DECERR are passed through unchanged, with no retry.
  - `rsp_rdata` is forwarded even on an error response.
- **Watchdog**
  - The counter clears on entry to any bus state and on every AXI handshake.
  - It increments in WADDR, WRESP, RADDR and RDATA, and saturates at TIMEOUT-1.
  - On reaching TIMEOUT-1, `timeout` sets. It clears only on the next command accept.
  - The transaction is never abandoned; the FSM keeps waiting.
- **Reset mid-transaction:** all VALID/READY outputs deassert immediately (asynchronous). No response is produced.

## Timing
- Command accepted at cycle 0; AXI VALID registered high at cycle 1.
- Best-case write: AW and W both ready at cycle 1, `BVALID` at cycle 2, `rsp_valid` at cycle 3.
- Best-case read: `ARREADY` at cycle 1, `RVALID` at cycle 2, `rsp_valid` at cycle 3.
- Throughput: back-to-back commands with zero slave wait reach at most one command per 4 cycles (IDLE → bus → resp → RSP).
- `BVALID`/`RVALID` arriving before READY is raised is held by the slave per AXI. Early arrival is safe because READY asserts on state entry.

## Structure
- Package `ddr_axil_pkg`:
  - state enum.
  - AXI response constants `RESP_OKAY`=0, `RESP_EXOKAY`=1, `RESP_SLVERR`=2, `RESP_DECERR`=3.
  - The same package is shared with `ddr_control`'s slave port.
- Sub-module `axil_watchdog`: a parameterised saturating counter with clear/enable inputs and a sticky flag output. Everything else stays in one module.

## Test plan
- Write `0x0000_1004`, data `0xDEADBEEF`, strb `0xF`, zero-wait slave, `BRESP`=0 → `AWADDR`=`0x1004`, `rsp_valid` at cycle 3, `rsp_resp`=0, `rsp_we`=1.
- Write with `WREADY` 3 cycles before `AWREADY` (and reversed) → `WVALID` drops after its handshake, `AWVALID` holds, exactly one of each handshake, one response.
- Read `0x0000_2002`, slave returns `0x12345678` with `RRESP`=2 after 5 wait cycles → `ARADDR`=`0x2000`, `rsp_rdata`=`0x12345678`, `rsp_resp`=2.
- `rsp_ready` low for 4 cycles → `rsp_*` stable, `cmd_ready`=0 throughout, IDLE is re-entered the cycle after `rsp_ready`.
- `TIMEOUT`=8, `ARREADY` held low for 20 cycles → `timeout`=1 after 7 stall cycles, `ARVALID` stays 1, completion proceeds normally, next accept clears `timeout`.
- `ARESETN` pulsed low while in WRESP → all outputs return to reset values asynchronously, no `rsp_valid`, and the next command works normally.
